// File: rtl/uart_baud_tick_gen.sv
// uart_baud_tick_gen: baud-rate clock-enable generator for the UART.
// It holds a table of NUM_SRC divisor profiles and switches between them
// glitch-free. A switch waits for a baud-period boundary, then leaves a
// settle gap with no ticks before the new profile starts.
//
// Ports:
//   PCLK       - sole clock, rising edge
//   PRESETn    - synchronous active-low reset
//   enable     - level, 1 = generate ticks
//   div_cfg    - divisor table, profile k at [k*DIV_W +: DIV_W]
//   src_sel    - requested profile, sampled with sel_req
//   sel_req    - one-cycle switch request
//   sel_ack    - pulse: requested profile now active
//   req_drop   - pulse: request rejected
//   busy       - switch pending or settling
//   active_sel - profile currently in use
//   tick_ovs   - oversample tick, one every eff cycles
//   tick_baud  - baud tick, coincides with every OVS-th tick_ovs
//   br_clk     - baud-rate square wave, high for the first half of a period
module uart_baud_tick_gen #(
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVS        = 16,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic                       enable,
  input  logic [NUM_SRC*DIV_W-1:0]   div_cfg,
  input  logic [$clog2(NUM_SRC)-1:0] src_sel,
  input  logic                       sel_req,
  output logic                       sel_ack,
  output logic                       req_drop,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] active_sel,
  output logic                       tick_ovs,
  output logic                       tick_baud,
  output logic                       br_clk
);

  localparam int unsigned SEL_W  = $clog2(NUM_SRC);
  localparam int unsigned SELX_W = SEL_W + 1;
  localparam int unsigned OVS_W  = $clog2(OVS);
  localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, SW_PEND, SETTLE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_sel_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [OVS_W-1:0]   ovs_cnt_q, ovs_d;
  logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
  logic [SET_W-1:0]   settle_cnt_q, settle_d;
  logic               pend_done_q, pend_done_d;
  logic               sel_ack_d, req_drop_d, busy_d;
  logic               tick_ovs_d, tick_baud_d, br_clk_d;

  logic [DIV_W-1:0]   div_tbl [NUM_SRC];
  logic               step_tick, step_baud, src_in_range, req_ok;
  logic [DIV_W-1:0]   step_cnt;
  logic [OVS_W-1:0]   step_ovs;

  // Reload value for the cycle counter; divisor 0 behaves as 1
  function automatic logic [DIV_W-1:0] eff_m1(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - DIV_W'(1);
  endfunction

  // Unpack the flat divisor table
  for (genvar k = 0; k < NUM_SRC; k++) begin : g_tbl
    assign div_tbl[k] = div_cfg[k*DIV_W +: DIV_W];
  end

  // One counting step with the latched divisor
  assign step_tick    = (cnt_q == '0);
  assign step_cnt     = step_tick ? eff_m1(div_q) : cnt_q - DIV_W'(1);
  assign step_ovs     = ovs_cnt_q + OVS_W'(step_tick);
  assign step_baud    = step_tick && (ovs_cnt_q == OVS_W'(OVS - 1));
  assign src_in_range = ({1'b0, src_sel} < SELX_W'(NUM_SRC));
  assign req_ok       = src_in_range && (src_sel != active_sel);

  // State and output registers
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      active_sel   <= '0;
      div_q        <= div_tbl[0];
      cnt_q        <= '0;
      ovs_cnt_q    <= '0;
      pend_sel_q   <= '0;
      settle_cnt_q <= '0;
      pend_done_q  <= 1'b0;
      sel_ack      <= 1'b0;
      req_drop     <= 1'b0;
      busy         <= 1'b0;
      tick_ovs     <= 1'b0;
      tick_baud    <= 1'b0;
      br_clk       <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_sel   <= active_sel_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      ovs_cnt_q    <= ovs_d;
      pend_sel_q   <= pend_sel_d;
      settle_cnt_q <= settle_d;
      pend_done_q  <= pend_done_d;
      sel_ack      <= sel_ack_d;
      req_drop     <= req_drop_d;
      busy         <= busy_d;
      tick_ovs     <= tick_ovs_d;
      tick_baud    <= tick_baud_d;
      br_clk       <= br_clk_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    active_sel_d = active_sel;
    div_d        = div_q;
    cnt_d        = cnt_q;
    ovs_d        = ovs_cnt_q;
    pend_sel_d   = pend_sel_q;
    settle_d     = settle_cnt_q;
    pend_done_d  = pend_done_q;
    sel_ack_d    = 1'b0;
    req_drop_d   = 1'b0;
    tick_ovs_d   = 1'b0;
    tick_baud_d  = 1'b0;
    br_clk_d     = 1'b0;

    if ((state_q != IDLE) && !enable) begin
      // Enable fall wins over any request; a pending switch completes now
      state_d     = IDLE;
      cnt_d       = '0;
      ovs_d       = '0;
      settle_d    = '0;
      pend_done_d = 1'b0;
      if (state_q != RUN) begin
        active_sel_d = pend_sel_q;
        div_d        = div_tbl[pend_sel_q];
        sel_ack_d    = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          ovs_d = '0;
          if (sel_req) begin
            if (req_ok) begin
              active_sel_d = src_sel;
              div_d        = div_tbl[src_sel];
              sel_ack_d    = 1'b1;
            end else begin
              req_drop_d = 1'b1;
            end
          end
          if (enable) begin
            div_d    = div_tbl[active_sel_d];
            cnt_d    = eff_m1(div_tbl[active_sel_d]);
            br_clk_d = 1'b1;
            state_d  = RUN;
          end
        end

        RUN: begin
          cnt_d       = step_cnt;
          ovs_d       = step_ovs;
          tick_ovs_d  = step_tick;
          tick_baud_d = step_baud;
          br_clk_d    = !step_ovs[OVS_W-1];
          if (sel_req) begin
            if (req_ok) begin
              pend_sel_d  = src_sel;
              pend_done_d = 1'b0;
              state_d     = SW_PEND;
            end else begin
              req_drop_d = 1'b1;
            end
          end
        end

        SW_PEND: begin
          req_drop_d = sel_req;
          if (pend_done_q) begin
            state_d     = SETTLE;
            settle_d    = SET_W'(SETTLE_CYC - 1);
            pend_done_d = 1'b0;
          end else begin
            cnt_d       = step_cnt;
            ovs_d       = step_ovs;
            tick_ovs_d  = step_tick;
            tick_baud_d = step_baud;
            // Hold br_clk low from the final old baud edge so no runt pulse appears
            br_clk_d    = !step_ovs[OVS_W-1] && !step_baud;
            if (step_baud) begin
              pend_done_d = 1'b1;
            end
          end
        end

        SETTLE: begin
          req_drop_d = sel_req;
          if (settle_cnt_q == '0) begin
            active_sel_d = pend_sel_q;
            div_d        = div_tbl[pend_sel_q];
            cnt_d        = eff_m1(div_tbl[pend_sel_q]);
            ovs_d        = '0;
            sel_ack_d    = 1'b1;
            br_clk_d     = 1'b1;
            state_d      = RUN;
          end else begin
            settle_d = settle_cnt_q - SET_W'(1);
          end
        end

        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == SW_PEND) || (state_d == SETTLE);
  end

endmodule

// File: tb/tb_uart_baud_tick_gen.sv
// Testbench for uart_baud_tick_gen: directed scenarios plus random stimulus,
// checked against a segment-based timing model of the tick streams.
module tb_uart_baud_tick_gen;

  localparam int unsigned NUM_SRC    = 3;
  localparam int unsigned DIV_W      = 16;
  localparam int unsigned OVS        = 16;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned SEL_W      = $clog2(NUM_SRC);

  logic                     PCLK    = 1'b0;
  logic                     PRESETn = 1'b0;
  logic                     enable  = 1'b0;
  logic                     sel_req = 1'b0;
  logic [SEL_W-1:0]         src_sel = '0;
  logic [NUM_SRC*DIV_W-1:0] div_cfg = {16'd0, 16'd2, 16'd4};
  logic                     sel_ack, req_drop, busy, tick_ovs, tick_baud, br_clk;
  logic [SEL_W-1:0]         active_sel;
  logic [7:0]               obs;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Model: a running segment starts at edge m_s with period m_eff; a switch
  // ends the old segment at baud edge m_b and starts the new one at m_load.
  bit         m_run  = 1'b0;
  bit         m_pend = 1'b0;
  int         m_s, m_eff, m_b, m_load;
  int         m_sel  = 0;
  int         m_psel = 0;
  bit         e_ack, e_drop;
  logic [7:0] exp_v;

  uart_baud_tick_gen #(
    .NUM_SRC(NUM_SRC), .DIV_W(DIV_W), .OVS(OVS), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .enable(enable), .div_cfg(div_cfg),
    .src_sel(src_sel), .sel_req(sel_req), .sel_ack(sel_ack), .req_drop(req_drop),
    .busy(busy), .active_sel(active_sel), .tick_ovs(tick_ovs),
    .tick_baud(tick_baud), .br_clk(br_clk)
  );

  assign obs = {sel_ack, req_drop, busy, active_sel, tick_ovs, tick_baud, br_clk};

  always #5 PCLK = ~PCLK;

  function automatic int cfg_eff(input int k);
    logic [DIV_W-1:0] d;
    d = div_cfg[k*DIV_W +: DIV_W];
    return (d == '0) ? 1 : int'(d);
  endfunction

  task automatic model_edge();
    bit busy_b;
    int src;
    e_ack  = 1'b0;
    e_drop = 1'b0;
    src    = int'(src_sel);
    busy_b = m_pend;
    if (!PRESETn) begin
      m_run  = 1'b0;
      m_pend = 1'b0;
      m_sel  = 0;
    end else if (!enable && (m_run || m_pend)) begin
      if (m_pend) begin
        m_sel  = m_psel;
        e_ack  = 1'b1;
        m_pend = 1'b0;
      end
      m_run = 1'b0;
    end else begin
      if (sel_req) begin
        if (busy_b || src >= int'(NUM_SRC) || src == m_sel) begin
          e_drop = 1'b1;
        end else if (m_run) begin
          m_pend = 1'b1;
          m_psel = src;
          m_b    = m_s + ((cyc - m_s) / (m_eff * OVS) + 1) * (m_eff * OVS);
          m_load = m_b + 1 + SETTLE_CYC;
        end else begin
          m_sel = src;
          e_ack = 1'b1;
        end
      end
      if (busy_b && cyc == m_load) begin
        m_sel  = m_psel;
        m_eff  = cfg_eff(m_sel);
        m_s    = cyc;
        m_pend = 1'b0;
        e_ack  = 1'b1;
      end
      if (!m_run && enable) begin
        m_run = 1'b1;
        m_eff = cfg_eff(m_sel);
        m_s   = cyc;
      end
    end
  endtask

  function automatic logic [7:0] model_out();
    logic o, b, br;
    int   d, p;
    o  = 1'b0;
    b  = 1'b0;
    br = 1'b0;
    p  = m_eff * OVS;
    if (m_run) begin
      if (m_pend && cyc == m_b) begin
        o = 1'b1;
        b = 1'b1;
      end else if (!(m_pend && cyc > m_b)) begin
        d  = cyc - m_s;
        o  = (d > 0) && (d % m_eff == 0);
        b  = (d > 0) && (d % p == 0);
        br = (d % p) < (p / 2);
      end
    end
    return {e_ack, e_drop, m_pend, SEL_W'(m_sel), o, b, br};
  endfunction

  // Advance one clock edge and compute the expected outputs for it
  task automatic advance();
    @(posedge PCLK);
    cyc++;
    model_edge();
    #1;
    exp_v = model_out();
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    enable  = 1'b1;
    sel_req = 1'b1;
    src_sel = 2'd1;
    for (int i = 0; i < 3; i++) begin
      advance();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
      end
    end
    PRESETn = 1'b1;
    enable  = 1'b0;
    sel_req = 1'b0;
    advance();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
    end
  endtask

  task automatic test_basic();
    int  last_o = -1;
    int  last_b = -1;
    int  hi_run = 0;
    int  lo_run = 0;
    bit  seen_hi = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 140; i++) begin
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (i == 0 || tick_ovs === 1'b1) begin
        if (last_o >= 0) begin
          vectors++;
          if (cyc - last_o != 4) begin
            miscompares++;
            $display("FAIL basic_ovs_period got=%0d exp=4", cyc - last_o);
          end
        end
        last_o = cyc;
      end
      if (tick_baud === 1'b1) begin
        vectors++;
        if (cyc - last_b != 64 && last_b >= 0) begin
          miscompares++;
          $display("FAIL basic_baud_period got=%0d exp=64", cyc - last_b);
        end
        last_b = cyc;
      end
      if (br_clk === 1'b1) begin
        seen_hi = 1'b1;
        hi_run++;
        if (lo_run > 0) begin
          vectors++;
          if (lo_run != 32) begin
            miscompares++;
            $display("FAIL basic_br_low got=%0d exp=32", lo_run);
          end
          lo_run = 0;
        end
      end else if (seen_hi) begin
        lo_run++;
        if (hi_run > 0) begin
          vectors++;
          if (hi_run != 32) begin
            miscompares++;
            $display("FAIL basic_br_high got=%0d exp=32", hi_run);
          end
          hi_run = 0;
        end
      end
    end
  endtask

  task automatic test_cfg_ignore();
    div_cfg[DIV_W-1:0] = 16'd7;
    for (int i = 0; i < 40; i++) begin
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL cfg_ignore cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
    div_cfg[DIV_W-1:0] = 16'd4;
  endtask

  task automatic test_switch();
    int acks = 0;
    for (int i = 0; i < 160; i++) begin
      sel_req = (i == 10);
      src_sel = 2'd1;
      advance();
      acks += int'(sel_ack);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL switch cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
    sel_req = 1'b0;
    vectors++;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL switch_ack_count got=%0d exp=1", acks);
    end
    vectors++;
    if (active_sel !== 2'd1) begin
      miscompares++;
      $display("FAIL switch_active got=%0d exp=1", active_sel);
    end
  endtask

  task automatic test_invalid();
    int drops = 0;
    for (int i = 0; i < 120; i++) begin
      sel_req = (i == 3) || (i == 6) || (i == 7) || (i == 100);
      src_sel = (i == 3) ? 2'd3 : (i == 7) ? 2'd2 : 2'd0;
      advance();
      drops += int'(req_drop);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL invalid cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
    sel_req = 1'b0;
    vectors++;
    if (drops != 3) begin
      miscompares++;
      $display("FAIL invalid_drop_count got=%0d exp=3", drops);
    end
  endtask

  task automatic test_div0();
    int last_b = -1;
    for (int i = 0; i < 160; i++) begin
      sel_req = (i == 2);
      src_sel = 2'd2;
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL div0 cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (i >= 120) begin
        vectors++;
        if (tick_ovs !== 1'b1) begin
          miscompares++;
          $display("FAIL div0_every_cycle cyc=%0d got=%b exp=1", cyc, tick_ovs);
        end
        if (tick_baud === 1'b1) begin
          if (last_b >= 0) begin
            vectors++;
            if (cyc - last_b != 16) begin
              miscompares++;
              $display("FAIL div0_baud_period got=%0d exp=16", cyc - last_b);
            end
          end
          last_b = cyc;
        end
      end
    end
    sel_req = 1'b0;
  endtask

  task automatic test_enable_drop_settle();
    int  t;
    bit  hit = 1'b0;
    sel_req = 1'b1;
    src_sel = 2'd1;
    advance();
    sel_req = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL drop_settle_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (m_pend && cyc == m_b + 2) hit = 1'b1;
      else advance();
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL drop_settle_reach got=timeout exp=settle");
    end
    enable = 1'b0;
    advance();
    vectors++;
    if ({sel_ack, busy, active_sel, tick_ovs} !== {1'b1, 1'b0, 2'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL drop_settle_idle got=%b exp=%b",
               {sel_ack, busy, active_sel, tick_ovs}, {1'b1, 1'b0, 2'd1, 1'b0});
    end
    for (int i = 0; i < 3; i++) advance();
    enable = 1'b1;
    advance();
    t   = cyc;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL drop_settle_restart cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (tick_ovs === 1'b1) begin
        hit = 1'b1;
        vectors++;
        if (cyc - t != 2) begin
          miscompares++;
          $display("FAIL drop_settle_first_tick got=%0d exp=2", cyc - t);
        end
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL drop_settle_first_tick got=timeout exp=2");
    end
  endtask

  task automatic test_reset_pending();
    int last_o = -1;
    sel_req = 1'b1;
    src_sel = 2'd0;
    advance();
    sel_req = 1'b0;
    PRESETn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      advance();
      vectors++;
      if (obs !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_pending cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
      end
    end
    PRESETn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_pending_run cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
      if (i == 0 || tick_ovs === 1'b1) begin
        if (last_o >= 0) begin
          vectors++;
          if (cyc - last_o != 4) begin
            miscompares++;
            $display("FAIL reset_pending_period got=%0d exp=4", cyc - last_o);
          end
        end
        last_o = cyc;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      PRESETn = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 149) == 0) enable = ~enable;
      sel_req = ($urandom_range(0, 39) == 0);
      src_sel = SEL_W'($urandom_range(0, 3));
      advance();
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%b exp=%b", cyc, obs, exp_v);
      end
    end
    sel_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cfg_ignore();
    test_switch();
    test_invalid();
    test_div0();
    test_enable_drop_settle();
    test_reset_pending();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_baud_tick_gen.md
# uart_baud_tick_gen

Synthesisable, parametrised baud-rate reference generator for the UART. It replaces free-running behavioural reference clocks with clock-enable ticks derived from PCLK. It holds a table of NUM_SRC divisor profiles and switches between them glitch-free, only on a baud-period boundary followed by a settle gap. Outputs feed the UART TX/RX oversampling logic and the verification scoreboard's baud checker.

## Interface
Parameters:
- NUM_SRC, 3: number of selectable divisor profiles (≥2)
- DIV_W, 16: divisor width
- OVS, 16: oversampling ticks per baud period (power of two, ≥4)
- SETTLE_CYC, 4: PCLK cycles with no ticks between old and new profile (≥1)

Ports:
- PCLK  in  1  sole clock; all logic on rising edge
- PRESETn  in  1  reset, synchronous, active-low
- enable  in  1  level; 1 = generate ticks
- div_cfg  in  NUM_SRC*DIV_W  divisor table; profile k at bits [k*DIV_W +: DIV_W]
- src_sel  in  $clog2(NUM_SRC)  requested profile, sampled with sel_req
- sel_req  in  1  one-cycle request to switch profile
- sel_ack  out  1  one-cycle pulse: requested profile now active
- req_drop  out  1  one-cycle pulse: request rejected
- busy  out  1  switch pending or settling
- active_sel  out  $clog2(NUM_SRC)  profile currently in use
- tick_ovs  out  1  one-cycle oversample tick
- tick_baud  out  1  one-cycle tick, coincident with every OVS-th tick_ovs
- br_clk  out  1  baud-rate square wave (high for ovs_cnt < OVS/2)

## Operation
- States: IDLE, RUN, SW_PEND, SETTLE.
- Registers: active_sel, div_q (latched divisor), cnt (DIV_W), ovs_cnt ($clog2(OVS)), pend_sel, settle_cnt.
- Effective divisor: eff = (div_q==0) ? 1 : div_q. Divisor 0 behaves as 1, giving a tick_ovs every cycle.
- div_q is loaded only on reset, on a switch, or on IDLE→RUN. div_cfg changes to the active profile are ignored until the next load.
- IDLE:
  - Counters held at 0; ticks and br_clk are 0.
  - Valid sel_req: active_sel and div_q updated; sel_ack pulses next cycle.
  - enable=1: load cnt=eff-1, go RUN.
- RUN:
  - cnt decrements. At cnt==0: tick_ovs=1, cnt reloads eff-1, ovs_cnt increments mod OVS.
  - tick_baud=1 when tick_ovs and ovs_cnt==OVS-1.
- Valid sel_req in RUN:
  - Latch pend_sel, go SW_PEND, busy=1.
  - Ticks continue with the old profile through the next tick_baud inclusive.
  - Cycle after that tick_baud: go SETTLE, settle_cnt=SETTLE_CYC-1.
- SETTLE:
  - No ticks; br_clk=0; settle_cnt decrements.
  - At settle_cnt==0: active_sel=pend_sel, div_q=div_cfg[pend_sel], cnt=eff-1, ovs_cnt=0, go RUN.
  - sel_ack pulses on the first RUN cycle.
- Rejected requests (req_drop pulse next cycle, no state change):
  - src_sel ≥ NUM_SRC.
  - sel_req while busy=1.
  - src_sel == active_sel while not busy. Also sets sel_ack=0.
- enable falls in RUN: go IDLE the next cycle; counters cleared.
- enable falls in SW_PEND or SETTLE: pending switch applied immediately, sel_ack pulses, go IDLE.
- PRESETn=0 on any edge:
  - State IDLE, active_sel=0, div_q=div_cfg[0], all counters 0.
  - Outputs 0, pending request discarded.

## Timing
- Reset value of every output is 0; active_sel is 0.
- Outputs are registered. With enable sampled high in cycle t (IDLE), the first tick_ovs occurs at cycle t+eff.
- The tick_ovs period is exactly eff cycles. The tick_baud period is exactly eff*OVS cycles.
- Switch gap: from the last old tick_baud to the first new tick_ovs is SETTLE_CYC+1+eff cycles.
- No tick_ovs or tick_baud is emitted during SETTLE.
- br_clk never produces a pulse shorter than eff cycles.
- Priority within one cycle: reset > enable fall > sel_req > counter activity.
- busy rises the cycle after an accepted sel_req and falls with sel_ack.

## Test plan
Common configuration: NUM_SRC=3, OVS=16, SETTLE_CYC=4, div_cfg={d0=4, d1=2, d2=0}.
- Reset, then enable=1: tick_ovs every 4 cycles. tick_baud every 64 cycles. br_clk high for 32 cycles, low for 32.
- sel_req, src_sel=1, mid-baud: old ticks continue until the tick_baud. Then 4 tick-free cycles. Then tick_ovs every 2 cycles. sel_ack pulses once and active_sel=1.
- Invalid requests: src_sel=3 gives req_drop. Second sel_req while busy gives req_drop. src_sel=active_sel gives req_drop. Tick stream is unchanged in all three cases.
- Select src_sel=2 (divisor 0): tick_ovs every cycle, tick_baud every 16 cycles.
- enable dropped during SETTLE: IDLE next cycle with sel_ack and active_sel updated. Re-enable: first tick_ovs after eff cycles.
- PRESETn low during SW_PEND: all outputs 0, active_sel=0, no sel_ack. After release and enable, period is 4 cycles again.
